// File: rtl/dma_copy.sv
// dma_copy
// Word-copy initiator for the single-port data memory bus. On an accepted
// start it copies len 32-bit words from src to dst. Each word takes one
// read cycle followed by one write cycle, in ascending address order.
//
// Parameters:
//   LEN_W     width of the word-count input and of the progress counter
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   start     copy request, sampled on a rising edge while busy=0
//   src       source byte address (bits [1:0] ignored)
//   dst       destination byte address (bits [1:0] ignored)
//   len       number of words to copy
//   busy      high while the copy is reading or writing
//   done      one-cycle pulse when the copy finishes
//   count     words written so far in the current or last copy
//   mem_we    memory write enable
//   mem_a     memory byte address, always word-aligned
//   mem_wd    memory write data
//   mem_rd    memory read data, combinational from mem_a
//   checksum  (only with DMA_COPY_CHECKSUM_EN) wrapping sum of the words read
//
// Configuration:
//   DMA_COPY_CHECKSUM_EN  adds the checksum output and its adder.

module dma_copy #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] count,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
`ifdef DMA_COPY_CHECKSUM_EN
    output logic [31:0]      checksum,
`endif
    input  logic [31:0]      mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] count_q;
    logic [31:0]      data_q;

    // Masking with a constant keeps every address bit in use while forcing
    // word alignment of both pointers.
    logic [31:0] src_aligned;
    logic [31:0] dst_aligned;
    assign src_aligned = src & 32'hFFFF_FFFC;
    assign dst_aligned = dst & 32'hFFFF_FFFC;

    // State register. Reset is asynchronous, so the decoded bus outputs
    // fall to 0 as soon as reset rises, even in the middle of a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus decode. The mem_* outputs depend only on registered
    // state, so start/src/dst/len never reach the memory port in the same cycle.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_a      = 32'h0;
        unique case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    state_next = (len != '0) ? READ : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            READ: begin
                busy       = 1'b1;
                mem_a      = src_ptr;
                state_next = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                mem_we     = 1'b1;
                mem_a      = dst_ptr;
                state_next = (remaining == LEN_W'(1)) ? DONE : READ;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The data register only changes in READ, so it doubles as the held
    // write-data value outside of WRITE cycles.
    assign mem_wd = data_q;
    assign count  = count_q;

    // Datapath: pointer/counter loading on start, read capture, write
    // bookkeeping. Pointer adds wrap naturally at 32 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr   <= 32'h0;
            dst_ptr   <= 32'h0;
            remaining <= '0;
            count_q   <= '0;
            data_q    <= 32'h0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        src_ptr   <= src_aligned;
                        dst_ptr   <= dst_aligned;
                        remaining <= len;
                        count_q   <= '0;
                    end
                end
                READ: begin
                    data_q  <= mem_rd;
                    src_ptr <= src_ptr + 32'd4;
                end
                WRITE: begin
                    dst_ptr   <= dst_ptr + 32'd4;
                    count_q   <= count_q + LEN_W'(1);
                    remaining <= remaining - LEN_W'(1);
                end
                default: begin
                    src_ptr <= src_ptr;
                end
            endcase
        end
    end

`ifdef DMA_COPY_CHECKSUM_EN
    logic [31:0] sum_q;

    // Running sum of every word captured in READ; cleared when a copy is
    // accepted and left holding its final value after DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 32'h0;
        end else if ((state == IDLE || state == DONE) && start) begin
            sum_q <= 32'h0;
        end else if (state == READ) begin
            sum_q <= sum_q + mem_rd;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy
// Directed bench for dma_copy. A 256-word memory model (byte address bits
// [9:2] select the word) sits on the DUT bus; expected values are worked out
// by hand for each copy.

module tb_dma_copy;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic [7:0]  count;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
`ifdef DMA_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem [0:255];
    logic        tbFill;
    logic        tbWrEn;
    logic [7:0]  tbWrAddr;
    logic [31:0] tbWrData;

    int errorCount;
    int checkCount;

    // Results gathered by applyStimulus for the caller to check.
    int          doneCyc;
    int          weCnt;
    logic [31:0] firstRdA;
    logic [31:0] lastRdA;
    logic [31:0] firstWrA;
    logic [31:0] firstWrD;
    logic        misaligned;
    logic [31:0] busyMask;
    logic [7:0]  doneCount;
    logic [31:0] doneChecksum;

    dma_copy #(.LEN_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
`ifdef DMA_COPY_CHECKSUM_EN
        .checksum (checksum),
`endif
        .mem_rd   (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'hDEAD_0000 | 32'(i);
    endfunction

    // Memory model: combinational read, writes on the rising edge. Bench
    // preloads go through the same process as DUT writes.
    assign mem_rd = mem[mem_a[9:2]];

    always @(posedge clk) begin
        if (tbFill) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (tbWrEn) begin
            mem[tbWrAddr] <= tbWrData;
        end
        if (mem_we) mem[mem_a[9:2]] <= mem_wd;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        tbWrEn = 1'b1;
        tbWrAddr = a;
        tbWrData = d;
        @(posedge clk); #1;
        tbWrEn = 1'b0;
    endtask

    // Issues a start (called #1 after an edge) and follows the copy until
    // done or the cycle budget runs out. Cycle c is the cycle after edge k+c-1,
    // i.e. cycle 1 is the first cycle after the accepting edge.
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d,
                                 input logic [7:0] l, input int maxCyc);
        logic sawRd;
        logic sawWr;
        src = s;
        dst = d;
        len = l;
        start = 1'b1;
        doneCyc = -1;
        weCnt = 0;
        firstRdA = 32'hX;
        lastRdA = 32'hX;
        firstWrA = 32'hX;
        firstWrD = 32'hX;
        misaligned = 1'b0;
        busyMask = 32'h0;
        doneCount = 8'hXX;
        doneChecksum = 32'hX;
        sawRd = 1'b0;
        sawWr = 1'b0;
        for (int c = 1; c <= maxCyc; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (c < 32) busyMask[c] = busy;
            if (mem_a[1:0] != 2'b00) misaligned = 1'b1;
            if (mem_we) begin
                weCnt++;
                if (!sawWr) begin
                    firstWrA = mem_a;
                    firstWrD = mem_wd;
                end
                sawWr = 1'b1;
            end else if (busy) begin
                if (!sawRd) firstRdA = mem_a;
                sawRd = 1'b1;
                lastRdA = mem_a;
            end
            if (done) begin
                doneCyc = c;
                doneCount = count;
`ifdef DMA_COPY_CHECKSUM_EN
                doneChecksum = checksum;
`endif
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        logic sawDone;
        errorCount = 0;
        checkCount = 0;
        reset = 1'b1;
        start = 1'b0;
        src = 32'h0;
        dst = 32'h0;
        len = 8'h0;
        tbFill = 1'b0;
        tbWrEn = 1'b0;
        tbWrAddr = 8'h0;
        tbWrData = 32'h0;

        // Reset state
        #1;
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        checkOutput("reset done", {31'b0, done}, 32'h0);
        checkOutput("reset count", {24'b0, count}, 32'h0);
        checkOutput("reset mem_we", {31'b0, mem_we}, 32'h0);
        checkOutput("reset mem_a", mem_a, 32'h0);
        checkOutput("reset mem_wd", mem_wd, 32'h0);

        // Preload memory while reset holds the DUT off the bus
        tbFill = 1'b1;
        @(posedge clk); #1;
        tbFill = 1'b0;
        preload(8'h00, 32'h11);
        preload(8'h01, 32'h22);
        preload(8'h02, 32'h33);
        preload(8'h03, 32'h44);
        preload(8'hC0, 32'hFFFF_FFFF);
        preload(8'hC1, 32'h0000_0002);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // Basic four-word copy 0x00 -> 0x40
        applyStimulus(32'h00, 32'h40, 8'd4, 40);
        checkOutput("copy4 done cycle", 32'(doneCyc), 32'd9);
        checkOutput("copy4 busy cycles", busyMask, 32'h0000_01FE);
        checkOutput("copy4 count", {24'b0, doneCount}, 32'd4);
        checkOutput("copy4 first read addr", firstRdA, 32'h00);
        checkOutput("copy4 first write addr", firstWrA, 32'h40);
        checkOutput("copy4 first write data", firstWrD, 32'h11);
        checkOutput("copy4 writes", 32'(weCnt), 32'd4);
        checkOutput("copy4 word16", mem[16], 32'h11);
        checkOutput("copy4 word17", mem[17], 32'h22);
        checkOutput("copy4 word18", mem[18], 32'h33);
        checkOutput("copy4 word19", mem[19], 32'h44);
        checkOutput("copy4 word20 untouched", mem[20], pat(20));

        // Zero-length copy, started back-to-back from the DONE cycle
        applyStimulus(32'h10, 32'h20, 8'd0, 10);
        checkOutput("len0 done cycle", 32'(doneCyc), 32'd1);
        checkOutput("len0 writes", 32'(weCnt), 32'd0);
        checkOutput("len0 busy cycles", busyMask, 32'h0);
        checkOutput("len0 count", {24'b0, doneCount}, 32'd0);
        checkOutput("len0 dst untouched", mem[8], pat(8));

        // Misaligned addresses are forced to word boundaries
        applyStimulus(32'h03, 32'h82, 8'd1, 10);
        checkOutput("align done cycle", 32'(doneCyc), 32'd3);
        checkOutput("align read addr", firstRdA, 32'h00);
        checkOutput("align write addr", firstWrA, 32'h80);
        checkOutput("align all aligned", {31'b0, misaligned}, 32'h0);
        checkOutput("align word32", mem[32], 32'h11);

        // Start during busy is ignored; start in DONE chains with no gap
        src = 32'h00;
        dst = 32'h100;
        len = 8'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("chain first busy", {31'b0, busy}, 32'h1);
        @(posedge clk); #1;
        src = 32'h08;
        dst = 32'h180;
        len = 8'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("chain ignored start read addr", mem_a, 32'h04);
        cyc = -1;
        for (int c = 4; c <= 20; c++) begin
            if (done) begin
                cyc = c - 1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput("chain first done cycle", 32'(cyc), 32'd5);
        checkOutput("chain first count", {24'b0, count}, 32'd2);
        src = 32'h08;
        dst = 32'h180;
        len = 8'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("chain second busy", {31'b0, busy}, 32'h1);
        checkOutput("chain second we", {31'b0, mem_we}, 32'h0);
        checkOutput("chain second read addr", mem_a, 32'h08);
        sawDone = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (done) begin
                sawDone = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput("chain second done", {31'b0, sawDone}, 32'h1);
        checkOutput("chain word64", mem[8'h40], 32'h11);
        checkOutput("chain word65", mem[8'h41], 32'h22);
        checkOutput("chain word96", mem[8'h60], 32'h33);
        checkOutput("chain word97 untouched", mem[8'h61], pat(8'h61));

        // Reset asserted in the third WRITE of an eight-word copy
        src = 32'h00;
        dst = 32'h200;
        len = 8'd8;
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
        end
        checkOutput("abort in third write", {31'b0, mem_we}, 32'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort mem_we", {31'b0, mem_we}, 32'h0);
        checkOutput("abort busy", {31'b0, busy}, 32'h0);
        checkOutput("abort done", {31'b0, done}, 32'h0);
        checkOutput("abort count", {24'b0, count}, 32'h0);
        checkOutput("abort mem_a", mem_a, 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        sawDone = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) sawDone = 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("abort no done after", {31'b0, sawDone}, 32'h0);
        checkOutput("abort word128", mem[8'h80], 32'h11);
        checkOutput("abort word129", mem[8'h81], 32'h22);
        checkOutput("abort word132 untouched", mem[8'h84], pat(8'h84));
        checkOutput("abort word133 untouched", mem[8'h85], pat(8'h85));
        checkOutput("abort word134 untouched", mem[8'h86], pat(8'h86));
        checkOutput("abort word135 untouched", mem[8'h87], pat(8'h87));

        // Source pointer wraps from 0xFFFFFFFC to 0
        applyStimulus(32'hFFFF_FFFC, 32'h3F0, 8'd2, 20);
        checkOutput("wrap done cycle", 32'(doneCyc), 32'd5);
        checkOutput("wrap first read", firstRdA, 32'hFFFF_FFFC);
        checkOutput("wrap second read", lastRdA, 32'h0);
        checkOutput("wrap word253", mem[8'hFD], 32'h11);

        // Maximum length: count reaches 255 without wrapping
        applyStimulus(32'h00, 32'h00, 8'd255, 600);
        checkOutput("maxlen done cycle", 32'(doneCyc), 32'd511);
        checkOutput("maxlen count", {24'b0, doneCount}, 32'd255);
        checkOutput("maxlen writes", 32'(weCnt), 32'd255);

`ifdef DMA_COPY_CHECKSUM_EN
        // Checksum wraps: 0xFFFFFFFF + 2 = 1
        applyStimulus(32'h300, 32'h308, 8'd2, 20);
        checkOutput("checksum done cycle", 32'(doneCyc), 32'd5);
        checkOutput("checksum value", doneChecksum, 32'h0000_0001);
        @(posedge clk); #1;
        checkOutput("checksum held", checksum, 32'h0000_0001);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
